sad_block_accum: RTL and testbench

- Downstream consumer of the 3-output combinational SAD cell.
- Accumulates the 3-bit partial SAD words produced per pixel group over SAMPLES groups, giving one candidate's block SAD.
- Tracks the minimum block SAD and its index across CAND candidates.
- Emits a per-candidate result pulse and a handshaked best-match result; used by the error-evaluation flow to compare exact and approximate SAD cells at block level.

---
 rtl/sad_pkg.sv | 19 +
 rtl/sad_min_tracker.sv | 37 +++
 rtl/sad_block_accum.sv | 126 ++++++++++++
 tb/tb_sad_block_accum.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths, width helpers and state type for the block SAD accumulator
package sad_pkg;

    localparam int PSAD_W_DEF = 3;

    function automatic int acc_w(input int psad_w, input int samples);
        return psad_w + $clog2(samples);
    endfunction

    function automatic int idx_w(input int cand);
        return $clog2(cand);
    endfunction

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

endpackage

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - running minimum block SAD and its candidate index
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int ACC_W = 7,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic             first,
    input  logic [ACC_W-1:0] value,
    input  logic [IDX_W-1:0] idx,
    output logic [ACC_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx
);

    logic take;

    // strict compare: an equal later candidate never displaces the earlier index
    assign take = update & (first | (value < best_sad));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sad <= '0;
            best_idx <= '0;
        end else if (clear) begin
            best_sad <= '0;
            best_idx <= '0;
        end else if (take) begin
            best_sad <= value;
            best_idx <= idx;
        end
    end

endmodule

// File: rtl/sad_block_accum.sv
// rtl/sad_block_accum.sv - block SAD accumulation and best-candidate search; SAD_EARLY_TERM_EN adds pruning
module sad_block_accum
    import sad_pkg::*;
#(
    parameter int PSAD_W  = PSAD_W_DEF,
    parameter int SAMPLES = 16,
    parameter int CAND    = 8,
    localparam int ACC_W  = acc_w(PSAD_W, SAMPLES),
    localparam int IDX_W  = idx_w(CAND)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSAD_W-1:0] in_psad,
    output logic              cand_valid,
    output logic [ACC_W-1:0]  cand_sad,
    output logic [IDX_W-1:0]  cand_idx,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef SAD_EARLY_TERM_EN
    output logic [IDX_W:0]    prune_cnt,
`endif
    output logic [ACC_W-1:0]  best_sad,
    output logic [IDX_W-1:0]  best_idx
);

    localparam int SC_W = $clog2(SAMPLES);

    state_t            state, state_d;
    logic [ACC_W-1:0]  acc;
    logic [SC_W-1:0]   samp_cnt;
    logic [IDX_W-1:0]  cand_cnt;
    logic              accept, last, last_cand, handshake;
    logic [ACC_W-1:0]  sum_full, final_sad;

    assign accept    = in_valid & in_ready & ~flush;
    assign last      = accept & (samp_cnt == SC_W'(SAMPLES - 1));
    assign last_cand = (cand_cnt == IDX_W'(CAND - 1));
    assign handshake = (state == RESULT) & out_ready;
    assign sum_full  = acc + ACC_W'(in_psad);

`ifdef SAD_EARLY_TERM_EN
    logic pruned;
    // once a later candidate can no longer beat the best, freeze its partial sum
    assign pruned    = (cand_cnt != '0) & (acc >= best_sad);
    assign final_sad = pruned ? acc : sum_full;
`else
    assign final_sad = sum_full;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (last && last_cand) state_d = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        if (flush) state_d = ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            samp_cnt   <= '0;
            cand_cnt   <= '0;
            cand_valid <= 1'b0;
            cand_sad   <= '0;
            cand_idx   <= '0;
        end else if (flush) begin
            acc        <= '0;
            samp_cnt   <= '0;
            cand_cnt   <= '0;
            cand_valid <= 1'b0;
        end else begin
            cand_valid <= last;
            if (accept) begin
                acc      <= last ? '0 : final_sad;
                samp_cnt <= last ? '0 : samp_cnt + 1'b1;
            end
            if (last) begin
                cand_sad <= final_sad;
                cand_idx <= cand_cnt;
                cand_cnt <= last_cand ? '0 : cand_cnt + 1'b1;
            end
        end
    end

`ifdef SAD_EARLY_TERM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    prune_cnt <= '0;
        else if (flush | handshake) prune_cnt <= '0;
        else if (last && pruned)    prune_cnt <= prune_cnt + 1'b1;
    end
`endif

    sad_min_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_min (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush | handshake),
        .update   (last),
        .first    (cand_cnt == '0),
        .value    (final_sad),
        .idx      (cand_cnt),
        .best_sad (best_sad),
        .best_idx (best_idx)
    );

endmodule

// File: tb/tb_sad_block_accum.sv
// tb/tb_sad_block_accum.sv - self-checking bench for sad_block_accum; SAD_EARLY_TERM_EN enables the pruning test
module tb_sad_block_accum;

    localparam int SAMPLES = 16;
    localparam int CAND    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_psad;
    logic       cand_valid;
    logic [6:0] cand_sad;
    logic [2:0] cand_idx;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] best_sad;
    logic [2:0] best_idx;
`ifdef SAD_EARLY_TERM_EN
    logic [3:0] prune_cnt;
`endif

    int total = 0;
    int bad   = 0;

    sad_block_accum dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_psad    (in_psad),
        .cand_valid (cand_valid),
        .cand_sad   (cand_sad),
        .cand_idx   (cand_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SAD_EARLY_TERM_EN
        .prune_cnt  (prune_cnt),
`endif
        .best_sad   (best_sad),
        .best_idx   (best_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sample lists per candidate, sums and minimum by plain arithmetic
    int  m_samples[$];
    int  m_sums[$];
    bit  m_result;
    bit  e_cv;
    int  e_cs, e_ci, e_best, e_bidx, e_prune;

    function automatic void model_clear();
        m_samples.delete();
        m_sums.delete();
        m_result = 1'b0;
        e_prune  = 0;
        e_best   = 0;
        e_bidx   = 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_clear();
            e_cv = 1'b0;
        end else begin
            e_cv = 1'b0;
            if (flush) begin
                model_clear();
            end else if (!m_result) begin
                if (in_valid) begin
                    m_samples.push_back(int'(in_psad));
                    if (m_samples.size() == SAMPLES) begin
                        int s;
                        s = 0;
`ifdef SAD_EARLY_TERM_EN
                        begin
                            int  bs;
                            bit  pr;
                            pr = 1'b0;
                            bs = 0;
                            foreach (m_sums[i]) if (i == 0 || m_sums[i] < bs) bs = m_sums[i];
                            foreach (m_samples[i]) begin
                                if (m_sums.size() > 0 && s >= bs) pr = 1'b1;
                                else s += m_samples[i];
                            end
                            if (pr) e_prune++;
                        end
`else
                        foreach (m_samples[i]) s += m_samples[i];
`endif
                        e_cv = 1'b1;
                        e_cs = s;
                        e_ci = m_sums.size();
                        m_sums.push_back(s);
                        m_samples.delete();
                        if (m_sums.size() == CAND) begin
                            m_result = 1'b1;
                            e_best   = m_sums[0];
                            e_bidx   = 0;
                            foreach (m_sums[i]) if (m_sums[i] < e_best) begin
                                e_best = m_sums[i];
                                e_bidx = i;
                            end
                        end
                    end
                end
            end else if (out_ready) begin
                model_clear();
            end
        end
    end

    int cap[$];

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(!m_result));
        chk("out_valid", int'(out_valid), int'(m_result));
        chk("cand_valid", int'(cand_valid), int'(e_cv));
        if (e_cv) begin
            chk("cand_sad", int'(cand_sad), e_cs);
            chk("cand_idx", int'(cand_idx), e_ci);
        end
        if (m_result) begin
            chk("best_sad", int'(best_sad), e_best);
            chk("best_idx", int'(best_idx), e_bidx);
        end
`ifdef SAD_EARLY_TERM_EN
        chk("prune_cnt", int'(prune_cnt), e_prune);
`endif
        if (cand_valid) cap.push_back(int'(cand_sad));
    end

    task automatic push(input int v);
        in_valid = 1'b1;
        in_psad  = 3'(v);
        @(negedge clk);
    endtask

    task automatic run_cand(input int v);
        for (int s = 0; s < SAMPLES; s++) push(v);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_psad   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_cand_valid", int'(cand_valid), 0);
        chk("rst_best_sad", int'(best_sad), 0);

        // descending constants: 112..0, best at index 7
        out_ready = 1'b1;
        cap.delete();
        for (int c = 0; c < CAND; c++)
            for (int s = 0; s < SAMPLES; s++) begin
                if (c == CAND - 1 && s == SAMPLES - 1) chk("t1_ov_early", int'(out_valid), 0);
                push(7 - c);
            end
        in_valid = 1'b0;
        chk("t1_ov_latency", int'(out_valid), 1);
        chk("t1_best_sad", int'(best_sad), 0);
        chk("t1_best_idx", int'(best_idx), 7);
        @(negedge clk);
        chk("t1_ov_drop", int'(out_valid), 0);
        chk("t1_ncand", cap.size(), 8);
        if (cap.size() == 8)
            for (int i = 0; i < 8; i++) chk("t1_cand_list", cap[i], 112 - 16 * i);

        // all-equal candidates: tie keeps index 0
        cap.delete();
        for (int c = 0; c < CAND; c++) run_cand(3);
        in_valid = 1'b0;
        chk("t2_best_sad", int'(best_sad), 48);
        chk("t2_best_idx", int'(best_idx), 0);
        @(negedge clk);
        chk("t2_ncand", cap.size(), 8);
        foreach (cap[i]) chk("t2_cand_sad", cap[i], 48);

        // held result: sums 32,48,64,80,96,112,0,16 -> best 0 at index 6
        out_ready = 1'b0;
        for (int c = 0; c < CAND; c++) run_cand((c + 2) % 8);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_in_ready", int'(in_ready), 0);
            chk("t3_hold_best_sad", int'(best_sad), 0);
            chk("t3_hold_best_idx", int'(best_idx), 6);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t3_post_in_ready", int'(in_ready), 1);
        chk("t3_post_out_valid", int'(out_valid), 0);
        run_cand(5);
        chk("t3_new_cand_valid", int'(cand_valid), 1);
        chk("t3_new_cand_idx", int'(cand_idx), 0);
        chk("t3_new_cand_sad", int'(cand_sad), 80);

        // flush on candidate 4, sample 9, with a sample presented
        for (int c = 1; c < 4; c++) run_cand(c);
        for (int s = 0; s < 9; s++) push(6);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_psad  = 3'd7;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_in_ready", int'(in_ready), 1);
        chk("t4_out_valid", int'(out_valid), 0);
        chk("t4_cand_valid", int'(cand_valid), 0);
        out_ready = 1'b1;
        for (int c = 0; c < CAND; c++) run_cand((c * 3) % 8);
        in_valid = 1'b0;
        chk("t4_best_sad", int'(best_sad), 0);
        chk("t4_best_idx", int'(best_idx), 0);
        @(negedge clk);

        // asynchronous reset in the middle of candidate 2
        run_cand(4);
        run_cand(4);
        for (int s = 0; s < 8; s++) push(4);
        #2 rst = 1'b1;
        #1;
        chk("t5_cand_sad", int'(cand_sad), 0);
        chk("t5_cand_idx", int'(cand_idx), 0);
        chk("t5_cand_valid", int'(cand_valid), 0);
        chk("t5_best_sad", int'(best_sad), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < CAND; c++) run_cand(7 - (c % 4));
        in_valid = 1'b0;
        chk("t5_best_sad2", int'(best_sad), 64);
        chk("t5_best_idx2", int'(best_idx), 3);
        @(negedge clk);

`ifdef SAD_EARLY_TERM_EN
        cap.delete();
        run_cand(1);
        run_cand(7);
        chk("et_prune_cnt", int'(prune_cnt), 1);
        for (int c = 2; c < CAND; c++) run_cand(7);
        in_valid = 1'b0;
        chk("et_best_sad", int'(best_sad), 16);
        chk("et_best_idx", int'(best_idx), 0);
        @(negedge clk);
        if (cap.size() >= 2) begin
            chk("et_cand0", cap[0], 16);
            chk("et_cand1", cap[1], 21);
        end else begin
            chk("et_ncand", cap.size(), 8);
        end
`endif

        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
